axis_rx_capture: RTL and testbench

AXI4-Stream slave capture buffer for the LMAC2 receive path. It accepts frames on an AXIS slave port and writes each beat into an internal data memory and a paired 32-bit control-word memory. Both memories are exposed through an asynchronous read port for the host or testbench to inspect. It is the receive-side counterpart of the AXIS master stimulus memory: its control-word/data-word layout is the one that stimulus memory is loaded with.

---
 rtl/lmac2_axis_pkg.sv | 23 ++
 rtl/axis_cap_ram.sv | 20 ++
 rtl/axis_rx_capture.sv | 131 +++++++++++++
 tb/tb_axis_rx_capture.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmac2_axis_pkg.sv
// lmac2_axis_pkg: control-word layout, FSM encoding and control-word builder
// shared by the LMAC2 AXIS RX capture buffer and the TX stimulus memory.
package lmac2_axis_pkg;
    localparam int CW_LAST     = 31;
    localparam int CW_SOF      = 30;
    localparam int CW_TRUNC    = 29;
    localparam int CW_FRM_LSB  = 16;
    localparam int CW_KEEP_LSB = 0;

    typedef enum logic [1:0] {ST_IDLE, ST_SOF, ST_IN_FRAME, ST_FULL} cap_state_e;

    function automatic logic [31:0] cw_build(input logic last, input logic sof, input logic trunc,
                                             input logic [11:0] frm, input logic [15:0] keep);
        logic [31:0] cw;
        cw = '0;
        cw[CW_LAST] = last;
        cw[CW_SOF] = sof;
        cw[CW_TRUNC] = trunc;
        cw[CW_FRM_LSB +: 12] = frm;
        cw[CW_KEEP_LSB +: 16] = keep;
        return cw;
    endfunction
endpackage

// File: rtl/axis_cap_ram.sv
// axis_cap_ram: simple dual-port RAM with synchronous write and asynchronous read.
module axis_cap_ram #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);
    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/axis_rx_capture.sv
// axis_rx_capture: AXIS slave capture buffer writing data and control words to RAM.
// RX_DROP_ON_FULL_EN: when full, keep accepting and discard beats, counting dropped frames.
module axis_rx_capture
    import lmac2_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                    rx_mac_aclk,
    input  logic                    reset,
    input  logic                    capture_en,
    input  logic                    capture_clr,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [ADDR_WIDTH-1:0]   mem_rd_address,
    output logic [31:0]             mem_rd_ctrl,
    output logic [DATA_WIDTH-1:0]   mem_rd_data,
    output logic [ADDR_WIDTH:0]     wr_count,
    output logic [15:0]             frame_count,
    output logic                    capture_full
`ifdef RX_DROP_ON_FULL_EN
    ,
    output logic [15:0]             drop_count
`endif
);
    localparam int KW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

    cap_state_e          state_q, state_d;
    logic [ADDR_WIDTH:0] wr_count_q, wr_count_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic                full_q, full_d;
    logic                wr_en;
    logic [15:0]         keep_ext;
    logic [31:0]         wr_ctrl;
`ifdef RX_DROP_ON_FULL_EN
    logic [15:0]         drop_count_q, drop_count_d;
`endif

    always_ff @(posedge rx_mac_aclk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_count_q    <= '0;
            frame_count_q <= '0;
            full_q        <= 1'b0;
`ifdef RX_DROP_ON_FULL_EN
            drop_count_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wr_count_q    <= wr_count_d;
            frame_count_q <= frame_count_d;
            full_q        <= full_d;
`ifdef RX_DROP_ON_FULL_EN
            drop_count_q  <= drop_count_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_count_d    = wr_count_q;
        frame_count_d = frame_count_q;
        full_d        = full_q;
`ifdef RX_DROP_ON_FULL_EN
        drop_count_d  = drop_count_q;
`endif
        if (capture_clr) begin
            state_d       = ST_IDLE;
            wr_count_d    = '0;
            frame_count_d = '0;
            full_d        = 1'b0;
`ifdef RX_DROP_ON_FULL_EN
            drop_count_d  = '0;
`endif
        end else if (state_q == ST_IDLE) begin
            state_d = capture_en ? ST_SOF : ST_IDLE;
        end else if (wr_en) begin
            wr_count_d    = wr_count_q + 1'b1;
            frame_count_d = frame_count_q + 16'(s_axis_tlast);
            full_d        = wr_count_q == LAST_ADDR;
            state_d       = full_d ? ST_FULL : !s_axis_tlast ? ST_IN_FRAME : capture_en ? ST_SOF : ST_IDLE;
        end
`ifdef RX_DROP_ON_FULL_EN
        else if (state_q == ST_FULL && s_axis_tvalid && s_axis_tlast && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 1'b1;
        end
`endif
    end

    always_comb begin
        s_axis_tready = (state_q == ST_SOF || state_q == ST_IN_FRAME) && !full_q;
`ifdef RX_DROP_ON_FULL_EN
        s_axis_tready = s_axis_tready || state_q == ST_FULL;
`endif
        // beats accepted while FULL are discards and never reach memory
        wr_en = s_axis_tvalid && s_axis_tready && !capture_clr && state_q != ST_FULL;
        keep_ext = '0;
        keep_ext[KW-1:0] = s_axis_tkeep;
        wr_ctrl = cw_build(s_axis_tlast, state_q == ST_SOF, wr_count_q == LAST_ADDR && !s_axis_tlast,
                           frame_count_q[11:0], keep_ext);
    end

    axis_cap_ram #(.WIDTH(32), .ADDR_WIDTH(ADDR_WIDTH)) u_ctrl_ram (
        .clk     (rx_mac_aclk),
        .we      (wr_en),
        .wr_addr (wr_count_q[ADDR_WIDTH-1:0]),
        .wr_data (wr_ctrl),
        .rd_addr (mem_rd_address),
        .rd_data (mem_rd_ctrl)
    );

    axis_cap_ram #(.WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_data_ram (
        .clk     (rx_mac_aclk),
        .we      (wr_en),
        .wr_addr (wr_count_q[ADDR_WIDTH-1:0]),
        .wr_data (s_axis_tdata),
        .rd_addr (mem_rd_address),
        .rd_data (mem_rd_data)
    );

    assign wr_count     = wr_count_q;
    assign frame_count  = frame_count_q;
    assign capture_full = full_q;
`ifdef RX_DROP_ON_FULL_EN
    assign drop_count   = drop_count_q;
`endif
endmodule

// File: tb/tb_axis_rx_capture.sv
// tb_axis_rx_capture: directed self-checking bench for axis_rx_capture (ADDR_WIDTH=4).
module tb_axis_rx_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        capture_en = 1'b0;
    logic        capture_clr = 1'b0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_ctrl;
    logic [63:0] rd_data;
    logic [4:0]  wr_count;
    logic [15:0] frame_count;
    logic        capture_full;
`ifdef RX_DROP_ON_FULL_EN
    logic [15:0] drop_count;
`endif
    int total = 0;
    int bad = 0;
    int cyc = 0;

    axis_rx_capture #(.DATA_WIDTH(64), .ADDR_WIDTH(4)) dut (
        .rx_mac_aclk    (clk),
        .reset          (reset),
        .capture_en     (capture_en),
        .capture_clr    (capture_clr),
        .s_axis_tdata   (tdata),
        .s_axis_tkeep   (tkeep),
        .s_axis_tlast   (tlast),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready),
        .mem_rd_address (rd_addr),
        .mem_rd_ctrl    (rd_ctrl),
        .mem_rd_data    (rd_data),
        .wr_count       (wr_count),
        .frame_count    (frame_count),
        .capture_full   (capture_full)
`ifdef RX_DROP_ON_FULL_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a);
        rd_addr = a;
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
        logic ok;
        ok = 1'b0;
        tvalid = 1'b1;
        tdata = d;
        tkeep = k;
        tlast = l;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = tready;
            sync();
        end
        tvalid = 1'b0;
        tlast = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: beat %h not accepted, tready=%b required 1", d, tready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sync();
        total += 4;
        if (tready !== 1'b0) begin bad++; $display("FAIL rst_tready: got %b want 0", tready); end
        if (wr_count !== 5'd0) begin bad++; $display("FAIL rst_wr_count: got %0d want 0", wr_count); end
        if (frame_count !== 16'd0) begin bad++; $display("FAIL rst_frame_count: got %0d want 0", frame_count); end
        if (capture_full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", capture_full); end
`ifdef RX_DROP_ON_FULL_EN
        total++;
        if (drop_count !== 16'd0) begin bad++; $display("FAIL rst_drop: got %0d want 0", drop_count); end
`endif
        reset = 1'b0;
        sync();
    endtask

    task automatic test_single_frame();
        capture_en = 1'b1;
        send(64'h1111111111111111, 8'hFF, 1'b0);
        send(64'h2222222222222222, 8'hFF, 1'b0);
        send(64'h3333333333333333, 8'hFF, 1'b1);
        total += 7;
        if (wr_count !== 5'd3) begin bad++; $display("FAIL sf_wr_count: got %0d want 3", wr_count); end
        if (frame_count !== 16'd1) begin bad++; $display("FAIL sf_frame_count: got %0d want 1", frame_count); end
        rd(0);
        if (rd_ctrl !== 32'h400000FF) begin bad++; $display("FAIL sf_ctrl0: got %h want 400000ff", rd_ctrl); end
        if (rd_data !== 64'h1111111111111111) begin bad++; $display("FAIL sf_data0: got %h want 1111111111111111", rd_data); end
        rd(1);
        if (rd_ctrl !== 32'h000000FF) begin bad++; $display("FAIL sf_ctrl1: got %h want 000000ff", rd_ctrl); end
        rd(2);
        if (rd_ctrl !== 32'h800000FF) begin bad++; $display("FAIL sf_ctrl2: got %h want 800000ff", rd_ctrl); end
        if (rd_data !== 64'h3333333333333333) begin bad++; $display("FAIL sf_data2: got %h want 3333333333333333", rd_data); end
    endtask

    task automatic test_partial_keep();
        sync();
        send(64'h4444444444444444, 8'h0F, 1'b1);
        total += 3;
        rd(3);
        if (rd_ctrl !== 32'hC001000F) begin bad++; $display("FAIL pk_ctrl3: got %h want c001000f", rd_ctrl); end
        if (wr_count !== 5'd4) begin bad++; $display("FAIL pk_wr_count: got %0d want 4", wr_count); end
        if (frame_count !== 16'd2) begin bad++; $display("FAIL pk_frame_count: got %0d want 2", frame_count); end
    endtask

    task automatic test_back_to_back();
        int c0;
        sync();
        c0 = cyc;
        send(64'h5555555555555555, 8'hFF, 1'b0);
        send(64'h6666666666666666, 8'hFF, 1'b1);
        send(64'h7777777777777777, 8'hFF, 1'b1);
        total += 6;
        if (cyc - c0 !== 3) begin bad++; $display("FAIL b2b_cycles: got %0d want 3", cyc - c0); end
        if (frame_count !== 16'd4) begin bad++; $display("FAIL b2b_frame_count: got %0d want 4", frame_count); end
        if (wr_count !== 5'd7) begin bad++; $display("FAIL b2b_wr_count: got %0d want 7", wr_count); end
        rd(4);
        if (rd_ctrl !== 32'h400200FF) begin bad++; $display("FAIL b2b_ctrl4: got %h want 400200ff", rd_ctrl); end
        rd(5);
        if (rd_ctrl !== 32'h800200FF) begin bad++; $display("FAIL b2b_ctrl5: got %h want 800200ff", rd_ctrl); end
        rd(6);
        if (rd_ctrl !== 32'hC00300FF) begin bad++; $display("FAIL b2b_ctrl6: got %h want c00300ff", rd_ctrl); end
    endtask

    task automatic test_clear();
        sync();
        capture_clr = 1'b1;
        sync();
        capture_clr = 1'b0;
        total += 4;
        if (wr_count !== 5'd0) begin bad++; $display("FAIL clr_wr_count: got %0d want 0", wr_count); end
        if (frame_count !== 16'd0) begin bad++; $display("FAIL clr_frame_count: got %0d want 0", frame_count); end
        if (tready !== 1'b0) begin bad++; $display("FAIL clr_tready: got %b want 0", tready); end
        rd(3);
        if (rd_ctrl !== 32'hC001000F) begin bad++; $display("FAIL clr_mem_kept: got %h want c001000f", rd_ctrl); end
    endtask

    task automatic test_en_midframe();
        sync();
        send(64'hA0, 8'hFF, 1'b0);
        capture_en = 1'b0;
        send(64'hA1, 8'hFF, 1'b0);
        send(64'hA2, 8'hFF, 1'b0);
        send(64'hA3, 8'hFF, 1'b1);
        total += 7;
        if (wr_count !== 5'd4) begin bad++; $display("FAIL en_wr_count: got %0d want 4", wr_count); end
        if (frame_count !== 16'd1) begin bad++; $display("FAIL en_frame_count: got %0d want 1", frame_count); end
        if (tready !== 1'b0) begin bad++; $display("FAIL en_tready_after_last: got %b want 0", tready); end
        rd(0);
        if (rd_ctrl !== 32'h400000FF) begin bad++; $display("FAIL en_ctrl0: got %h want 400000ff", rd_ctrl); end
        rd(3);
        if (rd_ctrl !== 32'h800000FF) begin bad++; $display("FAIL en_ctrl3: got %h want 800000ff", rd_ctrl); end
        if (rd_data !== 64'hA3) begin bad++; $display("FAIL en_data3: got %h want a3", rd_data); end
        sync();
        sync();
        if (tready !== 1'b0) begin bad++; $display("FAIL en_tready_hold: got %b want 0", tready); end
    endtask

    task automatic test_fill();
        sync();
        capture_en = 1'b1;
        capture_clr = 1'b1;
        sync();
        capture_clr = 1'b0;
        for (int i = 0; i < 16; i++) send(64'(256 + i), 8'hFF, 1'b0);
        total += 6;
        if (wr_count !== 5'd16) begin bad++; $display("FAIL fill_wr_count: got %0d want 16", wr_count); end
        if (capture_full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", capture_full); end
        rd(15);
        if (rd_ctrl !== 32'h200000FF) begin bad++; $display("FAIL fill_ctrl15: got %h want 200000ff", rd_ctrl); end
        if (rd_data !== 64'h10F) begin bad++; $display("FAIL fill_data15: got %h want 10f", rd_data); end
        rd(0);
        if (rd_ctrl !== 32'h400000FF) begin bad++; $display("FAIL fill_ctrl0: got %h want 400000ff", rd_ctrl); end
        if (rd_data !== 64'h100) begin bad++; $display("FAIL fill_data0: got %h want 100", rd_data); end
`ifndef RX_DROP_ON_FULL_EN
        sync();
        tvalid = 1'b1;
        tdata = 64'h999;
        tkeep = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (tready !== 1'b0) begin bad++; $display("FAIL fill_backpressure[%0d]: got %b want 0", i, tready); end
            sync();
        end
        tvalid = 1'b0;
        total += 2;
        if (wr_count !== 5'd16) begin bad++; $display("FAIL fill_wr_hold: got %0d want 16", wr_count); end
        if (frame_count !== 16'd0) begin bad++; $display("FAIL fill_frame_count: got %0d want 0", frame_count); end
`else
        sync();
        send(64'h110, 8'hFF, 1'b0);
        send(64'h111, 8'hFF, 1'b0);
        send(64'h112, 8'hFF, 1'b0);
        send(64'h113, 8'hFF, 1'b1);
        total += 6;
        if (drop_count !== 16'd1) begin bad++; $display("FAIL drop_count: got %0d want 1", drop_count); end
        if (frame_count !== 16'd0) begin bad++; $display("FAIL drop_frame_count: got %0d want 0", frame_count); end
        if (wr_count !== 5'd16) begin bad++; $display("FAIL drop_wr_count: got %0d want 16", wr_count); end
        if (tready !== 1'b1) begin bad++; $display("FAIL drop_tready: got %b want 1", tready); end
        rd(0);
        if (rd_ctrl !== 32'h400000FF) begin bad++; $display("FAIL drop_ctrl0: got %h want 400000ff", rd_ctrl); end
        if (rd_data !== 64'h100) begin bad++; $display("FAIL drop_data0: got %h want 100", rd_data); end
`endif
        sync();
        capture_clr = 1'b1;
        sync();
        capture_clr = 1'b0;
        total += 3;
        if (wr_count !== 5'd0) begin bad++; $display("FAIL fillclr_wr_count: got %0d want 0", wr_count); end
        if (capture_full !== 1'b0) begin bad++; $display("FAIL fillclr_full: got %b want 0", capture_full); end
        if (tready !== 1'b0) begin bad++; $display("FAIL fillclr_tready: got %b want 0", tready); end
`ifdef RX_DROP_ON_FULL_EN
        total++;
        if (drop_count !== 16'd0) begin bad++; $display("FAIL fillclr_drop: got %0d want 0", drop_count); end
`endif
    endtask

    task automatic test_clr_with_beat();
        sync();
        total += 6;
        if (tready !== 1'b1) begin bad++; $display("FAIL cwb_ready: got %b want 1", tready); end
        tvalid = 1'b1;
        tdata = 64'hDEAD;
        tkeep = 8'h0F;
        tlast = 1'b1;
        capture_clr = 1'b1;
        sync();
        tvalid = 1'b0;
        tlast = 1'b0;
        capture_clr = 1'b0;
        if (wr_count !== 5'd0) begin bad++; $display("FAIL cwb_wr_count: got %0d want 0", wr_count); end
        if (frame_count !== 16'd0) begin bad++; $display("FAIL cwb_frame_count: got %0d want 0", frame_count); end
        if (tready !== 1'b0) begin bad++; $display("FAIL cwb_tready: got %b want 0", tready); end
        rd(0);
        if (rd_data !== 64'h100) begin bad++; $display("FAIL cwb_data0: got %h want 100", rd_data); end
        if (rd_ctrl !== 32'h400000FF) begin bad++; $display("FAIL cwb_ctrl0: got %h want 400000ff", rd_ctrl); end
    endtask

    task automatic test_reset_midframe();
        sync();
        send(64'hB0, 8'hFF, 1'b0);
        send(64'hB1, 8'hFF, 1'b0);
        total += 6;
        if (wr_count !== 5'd2) begin bad++; $display("FAIL rmf_pre_wr_count: got %0d want 2", wr_count); end
        #2;
        reset = 1'b1;
        #1;
        if (tready !== 1'b0) begin bad++; $display("FAIL rmf_tready: got %b want 0", tready); end
        if (wr_count !== 5'd0) begin bad++; $display("FAIL rmf_wr_count: got %0d want 0", wr_count); end
        if (frame_count !== 16'd0) begin bad++; $display("FAIL rmf_frame_count: got %0d want 0", frame_count); end
        if (capture_full !== 1'b0) begin bad++; $display("FAIL rmf_full: got %b want 0", capture_full); end
        rd(1);
        if (rd_data !== 64'hB1) begin bad++; $display("FAIL rmf_mem_kept: got %h want b1", rd_data); end
        sync();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_partial_keep();
        test_back_to_back();
        test_clear();
        test_en_midframe();
        test_fill();
        test_clr_with_beat();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
